// File: rtl/rom_loader.sv
// rom_loader: UART-fed instruction ROM image loader that holds the core in reset until a checksummed image is written
module rom_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_n_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   DEPTH   = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

  logic [2:0]    sync_q;
  rx_state_e     rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_n_q, busy_q, done_q, err_q;
  logic [15:0]       n_new;
  logic              rx_in, rx_fall;

  assign rx_in   = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];
  assign n_new   = {rx_sh_q, len_lo_q};

  // Receiver: wait for a falling edge, re-check the start bit at half a bit, then sample each bit at its middle
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        rx_st_d  = rx_fall ? R_START : R_IDLE;
      end
      R_START:
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_in ? R_IDLE : R_DATA;
        end
      R_DATA:
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_in, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          rx_st_d  = (rx_bit_q == 3'd7) ? R_STOP : R_DATA;
        end
      default:
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_in;
          rx_ferr_d  = ~rx_in;
          rx_st_d    = R_IDLE;
        end
    endcase
  end

  // Loader: parse length, assemble little-endian words, track XOR checksum, and decide the next load state
  always_comb begin
    state_d  = state_q;
    addr_d   = (we_q && ~&addr_q) ? addr_q + ADDR_W'(1) : addr_q;
    wcnt_d   = wcnt_q;
    n_d      = (state_q == S_LEN1 && rx_valid_q) ? n_new : n_q;
    len_lo_d = (state_q == S_LEN0 && rx_valid_q) ? rx_sh_q : len_lo_q;
    lane_d   = lane_q;
    word_d   = word_q;
    xor_d    = xor_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE:
        if (load_en) begin
          state_d = S_LEN0;
          addr_d  = '0;
          wcnt_d  = '0;
          lane_d  = '0;
          xor_d   = '0;
        end
      S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
        if (state_q == S_DATA && rx_valid_q) begin
          word_d = {rx_sh_q, word_q[31:8]};
          xor_d  = xor_q ^ rx_sh_q;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {rx_sh_q, word_q[31:8]};
            wcnt_d  = wcnt_q + 16'd1;
          end
        end
        if (!load_en) state_d = S_IDLE;
        else if (rx_ferr_q) state_d = S_ERR;
        else if (rx_valid_q)
          case (state_q)
            S_LEN0:  state_d = S_LEN1;
            S_LEN1:  state_d = (n_new == 16'd0 || {1'b0, n_new} > DEPTH) ? S_ERR : S_DATA;
            S_DATA:  state_d = (lane_q == 2'd3 && wcnt_q == n_q - 16'd1) ? S_CSUM : S_DATA;
            default: state_d = (rx_sh_q == xor_q) ? S_DONE : S_ERR;
          endcase
      end
      default: state_d = load_en ? state_q : S_IDLE;
    endcase
  end

  // Receiver state, synchronizer and byte pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 3'b111;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], uart_rx};
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Loader state, datapath and registered outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wcnt_q       <= '0;
      n_q          <= '0;
      len_lo_q     <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      xor_q        <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wcnt_q       <= wcnt_d;
      n_q          <= n_d;
      len_lo_q     <= len_lo_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      xor_q        <= xor_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      busy_q       <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA) || (state_d == S_CSUM);
      done_q       <= state_d == S_DONE;
      err_q        <= state_d == S_ERR;
    end
  end

  assign rom_we_o     = we_q;
  assign rom_waddr_o  = addr_q;
  assign rom_wdata_o  = wdata_q;
  assign core_rst_n_o = core_rst_n_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized image loads checked against a byte-level image model
module tb_rom_loader;
  localparam int CPB = 4;
  localparam int AW  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          load_en = 1'b0;
  logic          rom_we_o;
  logic [AW-1:0] rom_waddr_o;
  logic [31:0]   rom_wdata_o;
  logic          core_rst_n_o, load_busy_o, load_done_o, load_err_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] img[$];
  int          wr_a[$];
  logic [31:0] wr_d[$];

  rom_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .load_en(load_en),
    .rom_we_o(rom_we_o), .rom_waddr_o(rom_waddr_o), .rom_wdata_o(rom_wdata_o),
    .core_rst_n_o(core_rst_n_o), .load_busy_o(load_busy_o),
    .load_done_o(load_done_o), .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rom_we_o) begin
      wr_a.push_back(int'(rom_waddr_o));
      wr_d.push_back(rom_wdata_o);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic busy, input logic done, input logic err, input logic crst);
    chk({tag, "_busy"}, 32'(load_busy_o), 32'(busy));
    chk({tag, "_done"}, 32'(load_done_o), 32'(done));
    chk({tag, "_err"}, 32'(load_err_o), 32'(err));
    chk({tag, "_crst"}, 32'(core_rst_n_o), 32'(crst));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_len(input int n);
    logic [15:0] v;
    v = 16'(n);
    send_byte(v[7:0]);
    send_byte(v[15:8]);
  endtask

  task automatic send_words(input int cnt, output logic [7:0] cs);
    logic [31:0] w;
    cs = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        cs ^= w[8*k +: 8];
        send_byte(w[8*k +: 8]);
      end
    end
  endtask

  task automatic send_img(input logic [7:0] cs_mask);
    logic [7:0] cs;
    send_len(img.size());
    send_words(img.size(), cs);
    send_byte(cs ^ cs_mask);
  endtask

  task automatic chk_writes(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(wr_a.size()), 32'(n));
    for (int i = 0; i < n && i < wr_a.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_a[i]), 32'(i));
      chk({tag, "_data"}, wr_d[i], img[i]);
    end
  endtask

  task automatic start_load();
    wr_a.delete();
    wr_d.delete();
    load_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic stop_load();
    load_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(rom_we_o), 0);
    chk({tag, "_waddr"}, 32'(rom_waddr_o), 0);
    chk({tag, "_wdata"}, rom_wdata_o, 0);
    chk_state(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] cs;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_state("rel", 1'b0, 1'b0, 1'b0, 1'b1);

    img = '{32'h0000_0013, 32'h0000_006F};
    start_load();
    chk_state("ld", 1'b1, 1'b0, 1'b0, 1'b0);
    send_len(2);
    send_words(2, cs);
    chk("plan_cs", 32'(cs), 32'h7C);
    send_byte(8'h7C);
    chk_writes("nom", 2);
    chk("nom_w0", wr_d[0], 32'h0000_0013);
    chk_state("nom", 1'b0, 1'b1, 1'b0, 1'b1);
    stop_load();
    chk_state("nom_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) img.push_back($urandom);
      start_load();
      send_img(8'h00);
      chk_writes("rnd", img.size());
      chk_state("rnd", 1'b0, 1'b1, 1'b0, 1'b1);
      stop_load();
    end

    img = '{32'h0000_0013, 32'h0000_006F};
    start_load();
    send_len(2);
    send_words(2, cs);
    send_byte(8'h00);
    chk_state("csum", 1'b0, 1'b0, 1'b1, 1'b0);
    stop_load();
    chk_state("csum_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    start_load();
    send_len(0);
    chk_state("len0", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_writes("len0", 0);
    stop_load();
    start_load();
    send_len(16'h1001);
    chk_state("lenbig", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_writes("lenbig", 0);
    stop_load();

    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    start_load();
    send_len(2);
    send_words(1, cs);
    chk_state("fe_pre", 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0);
    chk_state("fe", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_writes("fe", 1);
    stop_load();

    img = '{32'h0000_0013, 32'h0000_006F};
    start_load();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk_state("glitch", 1'b1, 1'b0, 1'b0, 1'b0);
    send_img(8'h00);
    chk_writes("glitch", 2);
    chk_state("glitch_end", 1'b0, 1'b1, 1'b0, 1'b1);
    stop_load();

    img.delete();
    for (int i = 0; i < 3; i++) img.push_back($urandom);
    start_load();
    send_len(3);
    send_words(1, cs);
    send_byte(8'h5A);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_state("abort", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10 * CPB) @(negedge clk);
    chk_writes("abort", 1);

    img.delete();
    for (int i = 0; i < 2; i++) img.push_back($urandom);
    start_load();
    send_len(2);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    wr_a.delete();
    wr_d.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    send_img(8'h00);
    chk_writes("rst_ld", 2);
    chk_state("rst_ld", 1'b0, 1'b1, 1'b0, 1'b1);
    stop_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
